// File: rtl/grf_pkg.sv
// Shared types and constants for the MIPS general register file.
// Optional feature macro used by this slice: GRF_BYPASS_EN.
package grf_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int DEPTH  = 1 << ADDR_W;

    typedef logic [ADDR_W-1:0] reg_idx_t;
    typedef logic [DATA_W-1:0] word_t;

    localparam reg_idx_t REG_ZERO = 5'd0;

    // Write request as seen by the array and by the read-port bypass.
    typedef struct packed {
        logic     we;
        reg_idx_t wa;
        word_t    wd;
    } wr_req_t;

    // A write only lands when enabled and not aimed at $0.
    function automatic logic wr_accepted(wr_req_t req);
        return req.we && (req.wa != REG_ZERO);
    endfunction

endpackage

// File: rtl/mips_grf_if.sv
// Decode/writeback bus of the MIPS register file.
// The driving stage uses the master modport, the register file uses slave.
// Optional feature macro (affects the register file only): GRF_BYPASS_EN.
interface mips_grf_if;
    import grf_pkg::*;

    logic [31:0] WPC;
    logic        we;
    reg_idx_t    RA1;
    reg_idx_t    RA2;
    reg_idx_t    WA;
    word_t       WD;
    word_t       RD1;
    word_t       RD2;

    modport master (
        output WPC, we, RA1, RA2, WA, WD,
        input  RD1, RD2
    );

    modport slave (
        input  WPC, we, RA1, RA2, WA, WD,
        output RD1, RD2
    );

endinterface

// File: rtl/grf_read_port.sv
// One combinational read port: address mux, $0 masking and, when
// GRF_BYPASS_EN is defined, same-cycle forwarding of the pending write.
module grf_read_port
    import grf_pkg::*;
(
    input  word_t    regs [DEPTH],
    input  reg_idx_t ra,
    input  wr_req_t  req,
    output word_t    rd
);

`ifndef GRF_BYPASS_EN
    // Without forwarding the pending write is not looked at here.
    logic unused_req;
    assign unused_req = ^req;
`endif

    // Select the addressed register, optionally forward, then force $0 to zero.
    always_comb begin
        // NOTE: assigning a default first keeps every path driven, so no latch is inferred.
        rd = regs[ra];
`ifdef GRF_BYPASS_EN
        if (wr_accepted(req) && (ra == req.wa)) begin
            rd = req.wd;
        end
`endif
        if (ra == REG_ZERO) begin
            rd = '0;
        end
    end

endmodule

// File: rtl/mips_grf.sv
// MIPS general register file: 32 x 32-bit, two combinational read ports,
// one synchronous write port, asynchronous active-low reset.
// Optional feature macro: GRF_BYPASS_EN (write-to-read forwarding).
module mips_grf
    import grf_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    mips_grf_if.slave   bus
);

    word_t   regs [DEPTH];
    wr_req_t req;

    assign req = '{we: bus.we, wa: bus.WA, wd: bus.WD};

    // Commit accepted writes on the rising edge; reset clears the whole array at once.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            // NOTE: the array is reset as flops on purpose; a reset memory cannot map to RAM macros.
            for (int i = 0; i < DEPTH; i++) begin
                // NOTE: sequential state uses non-blocking assignment so all flops update together.
                regs[i] <= '0;
            end
        end else if (wr_accepted(req)) begin
            regs[req.wa] <= req.wd;
        end
    end

    grf_read_port u_rd1 (
        .regs (regs),
        .ra   (bus.RA1),
        .req  (req),
        .rd   (bus.RD1)
    );

    grf_read_port u_rd2 (
        .regs (regs),
        .ra   (bus.RA2),
        .req  (req),
        .rd   (bus.RD2)
    );

`ifndef SYNTHESIS
    // Write trace: one line per accepted write, printed at the committing edge.
    always @(posedge clk) begin
        if (reset && wr_accepted(req)) begin
            $display("@%h: $%d <= %h", bus.WPC, bus.WA, bus.WD);
        end
    end
`endif

endmodule

// File: tb/tb_mips_grf.sv
// Self-checking bench for mips_grf: directed corner cases followed by
// randomized reads/writes against an array model of the register file.
// Expectations follow GRF_BYPASS_EN the same way as the design.
module tb_mips_grf;
    import grf_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   n_vec = 0;
    int   n_err = 0;
    word_t mdl [DEPTH];

    always #5 clk = ~clk;

    mips_grf_if bus ();

    mips_grf dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic check(input string tag, input word_t got, input word_t exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Expected value of a read port given the current bus inputs and the model.
    function automatic word_t ref_read(input reg_idx_t ra);
        if (reset !== 1'b1) return '0;
        if (ra == 0) return '0;
`ifdef GRF_BYPASS_EN
        if (bus.we && bus.WA != 0 && ra == bus.WA) return bus.WD;
`endif
        return mdl[ra];
    endfunction

    // Called just after a rising edge: drive, check reads before the next edge,
    // then let that edge commit and update the model.
    task automatic apply(input string tag, input logic we, input reg_idx_t wa,
                         input word_t wd, input reg_idx_t ra1, input reg_idx_t ra2);
        bus.we  = we;
        bus.WA  = wa;
        bus.WD  = wd;
        bus.RA1 = ra1;
        bus.RA2 = ra2;
        bus.WPC = 32'h0040_0000 + 32'(n_vec) * 4;
        #1;
        check({tag, "_rd1"}, bus.RD1, ref_read(ra1));
        check({tag, "_rd2"}, bus.RD2, ref_read(ra2));
        @(posedge clk);
        if (reset && we && wa != 0) mdl[wa] = wd;
        #1;
    endtask

    task automatic clear_model();
        for (int i = 0; i < DEPTH; i++) mdl[i] = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        clear_model();
        reset   = 1'b0;
        bus.we  = 1'b0;
        bus.WA  = '0;
        bus.WD  = '0;
        bus.WPC = '0;
        bus.RA1 = 5'd5;
        bus.RA2 = 5'd31;

        // 1: reads during reset, before and after an edge
        #7;
        check("reset_rd1", bus.RD1, 32'h0);
        check("reset_rd2", bus.RD2, 32'h0);
        @(posedge clk);
        #1;
        check("reset_edge_rd1", bus.RD1, 32'h0);
        #2 reset = 1'b1;
        @(posedge clk);
        #1;

        // 2: plain write then read back; unwritten neighbour stays 0
        apply("wr7", 1'b1, 5'd7, 32'h3, 5'd7, 5'd8);
        apply("rd7", 1'b0, 5'd0, 32'h0, 5'd7, 5'd8);
        check("rd7_value", bus.RD1, 32'h3);

        // 3: write to $0 is discarded
        apply("wr0", 1'b1, 5'd0, 32'h3, 5'd0, 5'd0);
        apply("rd0", 1'b0, 5'd0, 32'h0, 5'd0, 5'd7);
        check("rd0_value", bus.RD1, 32'h0);

        // 4: we=0 suppresses the write
        apply("nowe", 1'b0, 5'd6, 32'h5, 5'd6, 5'd6);
        apply("rd6", 1'b0, 5'd0, 32'h0, 5'd6, 5'd7);
        check("rd6_value", bus.RD1, 32'h0);

        // 5: async reset between edges clears immediately and blocks a pending write
        bus.we  = 1'b0;
        bus.RA1 = 5'd7;
        #1;
        check("pre_rst_rd1", bus.RD1, 32'h3);
        reset = 1'b0;
        #1;
        check("mid_rst_rd1", bus.RD1, 32'h0);
        clear_model();
        bus.we = 1'b1;
        bus.WA = 5'd7;
        bus.WD = 32'hFFFF_FFFF;
        @(posedge clk);
        #1;
        check("rst_blocks_wr", bus.RD1, 32'h0);
        bus.we = 1'b0;
        reset  = 1'b1;
        #1;
        check("after_rst_rd1", bus.RD1, 32'h0);

        // 6: same-cycle read of a pending write (forwarded only with bypass)
        apply("byp", 1'b1, 5'd9, 32'hDEAD_BEEF, 5'd0, 5'd9);
        apply("rd9", 1'b0, 5'd0, 32'h0, 5'd1, 5'd9);
        check("rd9_value", bus.RD2, 32'hDEAD_BEEF);

        // Randomized traffic with occasional mid-cycle reset pulses
        for (int it = 0; it < 400; it++) begin
            reg_idx_t wa, ra1, ra2;
            logic     we;
            word_t    wd;
            we  = ($urandom_range(0, 3) != 0);
            wa  = reg_idx_t'($urandom_range(0, 31));
            wd  = word_t'($urandom);
            ra1 = ($urandom_range(0, 3) == 0) ? wa : reg_idx_t'($urandom_range(0, 31));
            ra2 = ($urandom_range(0, 7) == 0) ? 5'd0 : reg_idx_t'($urandom_range(0, 31));
            if (it % 97 == 96) begin
                bus.we  = 1'b0;
                bus.RA1 = ra1;
                bus.RA2 = ra2;
                reset   = 1'b0;
                #1;
                clear_model();
                check("rnd_rst_rd1", bus.RD1, 32'h0);
                check("rnd_rst_rd2", bus.RD2, 32'h0);
                #1 reset = 1'b1;
            end
            apply("rnd", we, wa, wd, ra1, ra2);
        end

        // Final sweep of every register against the model
        for (int r = 0; r < DEPTH; r += 2) begin
            apply("sweep", 1'b0, 5'd0, 32'h0, reg_idx_t'(r), reg_idx_t'(r + 1));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
